// File: rtl/fp_multiplier_pipe.sv
// Three-stage pipelined floating-point multiplier with RNE rounding, flush-to-zero,
// special-value handling and a valid/ready handshake on both sides.
module fp_multiplier_pipe #(
  parameter int floatsize     = 32,
  parameter int exponentsize  = 8,
  parameter int exponent_bias = 2**(exponentsize-1)-1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [floatsize-1:0] argumenta,
  input  logic [floatsize-1:0] argumentb,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [floatsize-1:0] out,
  output logic                 overflow,
  output logic                 underflow
);

  localparam int SIG_W  = floatsize - exponentsize - 1;
  localparam int MAN_W  = SIG_W + 1;
  localparam int PROD_W = 2 * MAN_W;
  localparam int EXP_W  = exponentsize + 2;
  localparam logic [exponentsize-1:0] EXP_ONES = '1;
  localparam logic [floatsize-1:0]    QNAN     = {1'b0, EXP_ONES, 1'b1, {(SIG_W-1){1'b0}}};

  typedef enum logic [1:0] {CLS_NORM, CLS_ZERO, CLS_INF, CLS_NAN} cls_t;

  function automatic logic [SIG_W:0] round_rne(input logic [SIG_W-1:0] sig,
                                               input logic guard, input logic sticky);
    return {1'b0, sig} + {{SIG_W{1'b0}}, guard & (sticky | sig[0])};
  endfunction

  // Returns {overflow, underflow, word}; no denormal results are produced.
  function automatic logic [floatsize+1:0] saturate(input logic sign,
                                                    input logic signed [EXP_W-1:0] e,
                                                    input logic [SIG_W-1:0] sig);
    if (!e[EXP_W-1] && (e[EXP_W-2:0] >= {1'b0, EXP_ONES}))
      return {2'b10, sign, EXP_ONES, {SIG_W{1'b0}}};
    if (e[EXP_W-1] || (e == '0))
      return {2'b01, sign, {(floatsize-1){1'b0}}};
    return {2'b00, sign, e[exponentsize-1:0], sig};
  endfunction

  logic advance;
  logic vld_p0, vld_p1, vld_p2;

  assign advance   = !vld_p2 || out_ready;
  assign in_ready  = advance;
  assign out_valid = vld_p2;

  // Stage 1: unpack and classify
  logic [exponentsize-1:0] exp_a, exp_b;
  logic [SIG_W-1:0]        frac_a, frac_b;
  logic                    zero_a, zero_b, inf_a, inf_b, nan_a, nan_b;
  logic signed [EXP_W-1:0] exp_sum;
  cls_t                    cls_in;

  assign exp_a  = argumenta[floatsize-2 -: exponentsize];
  assign exp_b  = argumentb[floatsize-2 -: exponentsize];
  assign frac_a = argumenta[SIG_W-1:0];
  assign frac_b = argumentb[SIG_W-1:0];
  assign zero_a = (exp_a == '0);
  assign zero_b = (exp_b == '0);
  assign inf_a  = (exp_a == EXP_ONES) && (frac_a == '0);
  assign inf_b  = (exp_b == EXP_ONES) && (frac_b == '0);
  assign nan_a  = (exp_a == EXP_ONES) && (frac_a != '0);
  assign nan_b  = (exp_b == EXP_ONES) && (frac_b != '0);
  assign exp_sum = $signed({2'b00, exp_a}) + $signed({2'b00, exp_b})
                 - $signed(EXP_W'(exponent_bias));

  always_comb begin
    cls_in = CLS_NORM;
    if (nan_a || nan_b || (inf_a && zero_b) || (inf_b && zero_a)) cls_in = CLS_NAN;
    else if (inf_a || inf_b)                                         cls_in = CLS_INF;
    else if (zero_a || zero_b)                                       cls_in = CLS_ZERO;
  end

  logic                    sign_p0, sign_p1;
  cls_t                    cls_p0, cls_p1;
  logic signed [EXP_W-1:0] exp_p0, exp_p1;
  logic [MAN_W-1:0]        man_a_p0, man_b_p0;
  logic [PROD_W-1:0]       prod_p1;

  always_ff @(posedge clk) begin
    if (advance) begin
      sign_p0  <= argumenta[floatsize-1] ^ argumentb[floatsize-1];
      cls_p0   <= cls_in;
      exp_p0   <= exp_sum;
      man_a_p0 <= {1'b1, frac_a};
      man_b_p0 <= {1'b1, frac_b};
      // Stage 2: significand product
      sign_p1  <= sign_p0;
      cls_p1   <= cls_p0;
      exp_p1   <= exp_p0;
      prod_p1  <= PROD_W'(man_a_p0) * PROD_W'(man_b_p0);
    end
  end

  // Stage 3: normalise, round, pack
  logic [PROD_W-2:0]       norm;
  logic signed [EXP_W-1:0] exp_n, exp_r;
  logic [SIG_W:0]          rnd;
  logic [floatsize+1:0]    sat_word;
  logic [floatsize-1:0]    res_word;
  logic                    res_ovf, res_unf;

  // norm drops the leading one, so its top bits are the fraction proper.
  assign norm     = prod_p1[PROD_W-1] ? prod_p1[PROD_W-2:0] : {prod_p1[PROD_W-3:0], 1'b0};
  assign exp_n    = exp_p1 + $signed(EXP_W'(prod_p1[PROD_W-1]));
  assign rnd      = round_rne(norm[PROD_W-2 -: SIG_W], norm[PROD_W-2-SIG_W],
                              |norm[PROD_W-3-SIG_W:0]);
  assign exp_r    = exp_n + $signed(EXP_W'(rnd[SIG_W]));
  assign sat_word = saturate(sign_p1, exp_r, rnd[SIG_W-1:0]);

  always_comb begin
    res_word = sat_word[floatsize-1:0];
    res_ovf  = sat_word[floatsize+1];
    res_unf  = sat_word[floatsize];
    case (cls_p1)
      CLS_NAN: begin
        res_word = QNAN;
        res_ovf  = 1'b0;
        res_unf  = 1'b0;
      end
      CLS_INF: begin
        res_word = {sign_p1, EXP_ONES, {SIG_W{1'b0}}};
        res_ovf  = 1'b0;
        res_unf  = 1'b0;
      end
      CLS_ZERO: begin
        res_word = {sign_p1, {(floatsize-1){1'b0}}};
        res_ovf  = 1'b0;
        res_unf  = 1'b0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p0    <= 1'b0;
      vld_p1    <= 1'b0;
      vld_p2    <= 1'b0;
      out       <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else if (advance) begin
      vld_p0    <= in_valid;
      vld_p1    <= vld_p0;
      vld_p2    <= vld_p1;
      out       <= res_word;
      overflow  <= res_ovf;
      underflow <= res_unf;
    end
  end

endmodule

// File: tb/tb_fp_multiplier_pipe.sv
// Self-checking bench for fp_multiplier_pipe: directed vectors, backpressure,
// mid-flight reset and randomized traffic against an integer-arithmetic model.
module tb_fp_multiplier_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] argumenta;
  logic [31:0] argumentb;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out;
  logic        overflow;
  logic        underflow;

  int tests  = 0;
  int failed = 0;
  int popped = 0;
  bit accepted;
  logic [33:0] exp_q[$];

  fp_multiplier_pipe dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .argumenta (argumenta),
    .argumentb (argumentb),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out       (out),
    .overflow  (overflow),
    .underflow (underflow)
  );

  always #5 clk = ~clk;

  // Reference: exact integer product, then RNE by quotient/remainder. Returns {ovf, unf, word}.
  function automatic logic [33:0] model(input logic [31:0] a, input logic [31:0] b);
    int ea, eb, e, s;
    bit az, bz, ai, bi, an, bn, sg;
    longint p, q, r, half;
    ea = int'(a[30:23]);
    eb = int'(b[30:23]);
    az = (ea == 0);
    bz = (eb == 0);
    ai = (ea == 255) && (a[22:0] == 0);
    bi = (eb == 255) && (b[22:0] == 0);
    an = (ea == 255) && (a[22:0] != 0);
    bn = (eb == 255) && (b[22:0] != 0);
    sg = a[31] ^ b[31];
    if (an || bn || (ai && bz) || (bi && az)) return {2'b00, 32'h7FC00000};
    if (ai || bi) return {2'b00, sg, 8'hFF, 23'h0};
    if (az || bz) return {2'b00, sg, 31'h0};
    p = longint'({1'b1, a[22:0]}) * longint'({1'b1, b[22:0]});
    s = (p >= (longint'(1) << 47)) ? 24 : 23;
    e = ea + eb - 127 + (s - 23);
    q = p >> s;
    r = p - (q << s);
    half = longint'(1) << (s - 1);
    if (r > half || (r == half && q[0])) q = q + 1;
    if (q == (longint'(1) << 24)) begin
      q = q >> 1;
      e = e + 1;
    end
    if (e >= 255) return {2'b10, sg, 8'hFF, 23'h0};
    if (e <= 0)   return {2'b01, sg, 31'h0};
    return {2'b00, sg, e[7:0], q[22:0]};
  endfunction

  function automatic logic [31:0] rand_fp();
    logic [7:0]  e;
    logic [22:0] f;
    int sel;
    sel = $urandom_range(0, 9);
    case (sel)
      0:       e = 8'h00;
      1:       e = 8'hFF;
      2:       e = 8'($urandom_range(1, 20));
      3:       e = 8'($urandom_range(230, 254));
      default: e = 8'($urandom_range(100, 154));
    endcase
    f = 23'($urandom);
    if ($urandom_range(0, 5) == 0) f = 23'h0;
    return {1'($urandom), e, f};
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    tests++;
    assert (obs === expv) else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  // Called at posedge+1; samples at the falling edge, then advances one cycle.
  task automatic tick();
    #4;
    accepted = in_valid && in_ready;
    if (out_valid) begin
      if (exp_q.size() == 0) begin
        check("unexpected_out_valid", 64'(out_valid), 64'(0));
      end else begin
        check("result", 64'({overflow, underflow, out}), 64'(exp_q[0]));
        if (out_ready) begin
          void'(exp_q.pop_front());
          popped++;
        end
      end
    end
    if (accepted) exp_q.push_back(model(argumenta, argumentb));
    @(posedge clk);
    #1;
  endtask

  task automatic directed(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic [33:0] want);
    in_valid  = 1'b1;
    argumenta = a;
    argumentb = b;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    check(tag, 64'({out_valid, overflow, underflow, out}), 64'({1'b1, want}));
    tick();
  endtask

  task automatic push_until_accepted(input logic [31:0] a, input logic [31:0] b);
    int budget;
    in_valid  = 1'b1;
    argumenta = a;
    argumentb = b;
    budget = 0;
    do begin
      tick();
      budget++;
    end while (!accepted && budget < 20);
    check("accept_timeout", 64'(accepted), 64'(1));
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    argumenta = '0;
    argumentb = '0;
    #1;
    check("reset_state", 64'({out_valid, overflow, underflow, out}), 64'(0));
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Back-to-back latency and throughput
    out_ready = 1'b1;
    in_valid  = 1'b1;
    argumenta = 32'h3F800000;
    argumentb = 32'h42200000;
    tick();
    argumenta = 32'h3FC00000;
    argumentb = 32'h3FC00000;
    tick();
    in_valid = 1'b0;
    check("lat_not_early", 64'(out_valid), 64'(0));
    tick();
    check("lat_first", 64'({out_valid, overflow, underflow, out}), 64'({3'b100, 32'h42200000}));
    tick();
    check("lat_second", 64'({out_valid, overflow, underflow, out}), 64'({3'b100, 32'h40100000}));
    tick();

    directed("rne_tie",      32'h3F800001, 32'h3FC00000, {2'b00, 32'h3FC00002});
    directed("round_down",   32'h3F800001, 32'h3F800001, {2'b00, 32'h3F800002});
    directed("neg_zero",     32'h80000000, 32'h3F800000, {2'b00, 32'h80000000});
    directed("denorm_flush", 32'h00000001, 32'h42200000, {2'b00, 32'h00000000});
    directed("inf_neg",      32'h7F800000, 32'hBF800000, {2'b00, 32'hFF800000});
    directed("inf_x_zero",   32'h7F800000, 32'h00000000, {2'b00, 32'h7FC00000});
    directed("nan_in",       32'h7FC00001, 32'h3F800000, {2'b00, 32'h7FC00000});
    directed("overflow",     32'h7F000000, 32'h40000000, {2'b10, 32'h7F800000});
    directed("underflow",    32'h00800000, 32'h3F000000, {2'b01, 32'h00000000});
    directed("neg_overflow", 32'hFF000000, 32'h40000000, {2'b10, 32'hFF800000});

    // Backpressure: five distinct operations, output held
    out_ready = 1'b0;
    popped = 0;
    for (int k = 0; k < 3; k++) push_until_accepted(32'h40000000 + (k << 16), 32'h3FC00000);
    in_valid  = 1'b1;
    argumenta = 32'h40030000;
    argumentb = 32'h3FC00000;
    #1;
    check("bp_in_ready_low", 64'(in_ready), 64'(0));
    repeat (4) tick();
    check("bp_no_accept_stalled", 64'(exp_q.size()), 64'(3));
    check("bp_held_out", 64'(out), 64'(32'h40400000));
    out_ready = 1'b1;
    push_until_accepted(32'h40030000, 32'h3FC00000);
    push_until_accepted(32'h40040000, 32'h3FC00000);
    in_valid = 1'b0;
    repeat (6) tick();
    check("bp_all_out", 64'(popped), 64'(5));
    check("bp_drained", 64'(exp_q.size()), 64'(0));

    // Asynchronous reset with two operations in flight
    in_valid  = 1'b1;
    argumenta = 32'h40400000;
    argumentb = 32'h40400000;
    tick();
    argumenta = 32'h40800000;
    tick();
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("rst_async_valid", 64'(out_valid), 64'(0));
    check("rst_async_out", 64'(out), 64'(0));
    exp_q.delete();
    @(posedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;
    repeat (4) tick();
    directed("post_reset", 32'h40400000, 32'h40A00000, {2'b00, 32'h41700000});

    // Randomized traffic with random stalls
    for (int i = 0; i < 400; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      argumenta = rand_fp();
      argumentb = rand_fp();
      tick();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (8) tick();
    check("random_drained", 64'(exp_q.size()), 64'(0));

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
